// File: rtl/led_pattern_gen_if.sv
// Configuration bus for led_pattern_gen: one-cycle write strobe carrying
// the target channel, its new mode and, for bursts, the pulse count.
interface led_pattern_gen_if #(
   parameter int CH_W    = 2,
   parameter int BURST_W = 4
);
   logic               cfg_we;
   logic [CH_W-1:0]    cfg_ch;
   logic [2:0]         cfg_mode;
   logic [BURST_W-1:0] cfg_cnt;

   modport master (output cfg_we, output cfg_ch, output cfg_mode, output cfg_cnt);
   modport slave  (input  cfg_we, input  cfg_ch, input  cfg_mode, input  cfg_cnt);
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver. All channels share one prescaler and
// slow-phase counter, so blink edges of different channels line up.
//
// Per-channel mode FSM:
//   state   | meaning
//   M_OFF   | led held low (also reserved mode codes 5-7)
//   M_ON    | led held high
//   M_SLOW  | led toggles on every slow event
//   M_FAST  | led toggles on every fast event (base tick)
//   M_BURST | counted on-pulses paced by slow events, then OFF with done pulse
module led_pattern_gen #(
   parameter int CH_NUM       = 4,
   parameter int TICK_CNT_MAX = 15_625_000,
   parameter int SLOW_DIV     = 4,
   parameter int BURST_W      = 4,
   localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   led_pattern_gen_if.slave    cfg,
   output logic [CH_NUM-1:0]   led,
   output logic [CH_NUM-1:0]   busy,
   output logic [CH_NUM-1:0]   done
);

   localparam int CNT_W = (TICK_CNT_MAX > 1) ? $clog2(TICK_CNT_MAX) : 1;
   localparam int PH_W  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CNT_MAX - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SLOW_DIV - 1);

   typedef enum logic [2:0] {
      M_OFF   = 3'd0,
      M_ON    = 3'd1,
      M_SLOW  = 3'd2,
      M_FAST  = 3'd3,
      M_BURST = 3'd4
   } mode_t;

   logic [CNT_W-1:0]   cnt_q;
   logic [PH_W-1:0]    phase_q;
   logic               tick;
   logic               fast_ev;
   logic               slow_ev;

   mode_t              mode_q   [CH_NUM];
   mode_t              mode_nxt [CH_NUM];
   logic [BURST_W-1:0] rem_q    [CH_NUM];
   logic [BURST_W-1:0] rem_nxt  [CH_NUM];
   logic [CH_NUM-1:0]  led_q, led_nxt;
   logic [CH_NUM-1:0]  done_q, done_nxt;

   assign tick    = (cnt_q == CNT_LAST);
   assign fast_ev = tick;
   assign slow_ev = tick && (phase_q == PH_LAST);

   // Shared timebase: free-running prescaler and slow-phase counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= '0;
      end else if (tick) begin
         cnt_q   <= '0;
         phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      end else begin
         cnt_q   <= cnt_q + CNT_W'(1);
      end
   end

   // Per-channel state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH_NUM; i++) begin
            mode_q[i] <= M_OFF;
            rem_q[i]  <= '0;
         end
         led_q  <= '0;
         done_q <= '0;
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            mode_q[i] <= mode_nxt[i];
            rem_q[i]  <= rem_nxt[i];
         end
         led_q  <= led_nxt;
         done_q <= done_nxt;
      end
   end

   // Next-state: a write to a channel overrides any event in the same cycle;
   // out-of-range channel numbers match no channel and are dropped.
   always_comb begin
      led_nxt  = led_q;
      done_nxt = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         mode_nxt[i] = mode_q[i];
         rem_nxt[i]  = rem_q[i];
         if (cfg.cfg_we && (int'(cfg.cfg_ch) == i)) begin
            rem_nxt[i] = '0;
            case (cfg.cfg_mode)
               3'd1: begin mode_nxt[i] = M_ON;   led_nxt[i] = 1'b1; end
               3'd2: begin mode_nxt[i] = M_SLOW; led_nxt[i] = 1'b1; end
               3'd3: begin mode_nxt[i] = M_FAST; led_nxt[i] = 1'b1; end
               3'd4: begin
                  if (cfg.cfg_cnt == '0) begin
                     mode_nxt[i] = M_OFF;
                     led_nxt[i]  = 1'b0;
                     done_nxt[i] = 1'b1;
                  end else begin
                     mode_nxt[i] = M_BURST;
                     led_nxt[i]  = 1'b1;
                     rem_nxt[i]  = cfg.cfg_cnt;
                  end
               end
               default: begin mode_nxt[i] = M_OFF; led_nxt[i] = 1'b0; end
            endcase
         end else begin
            case (mode_q[i])
               M_SLOW: if (slow_ev) led_nxt[i] = ~led_q[i];
               M_FAST: if (fast_ev) led_nxt[i] = ~led_q[i];
               M_BURST: begin
                  if (slow_ev) begin
                     if (led_q[i]) begin
                        led_nxt[i] = 1'b0;
                        rem_nxt[i] = rem_q[i] - BURST_W'(1);
                        if (rem_q[i] == BURST_W'(1)) begin
                           mode_nxt[i] = M_OFF;
                           done_nxt[i] = 1'b1;
                        end
                     end else begin
                        led_nxt[i] = 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Busy simply reflects channels currently running a burst.
   always_comb begin
      busy = '0;
      for (int i = 0; i < CH_NUM; i++) busy[i] = (mode_q[i] == M_BURST);
   end

   assign led  = led_q;
   assign done = done_q;

endmodule
